// File: rtl/snow64_bfloat16_vector_add_seq_pkg.sv
// snow64_bfloat16_vector_add_seq_pkg: shared sizes and sequencer state type for the BFloat16 vector add path
package snow64_bfloat16_vector_add_seq_pkg;
    localparam int WIDTH__VECTOR_DATA = 256;
    localparam int NUM_BFLOAT16_LANES = 16;
    typedef enum logic [1:0] {
        StVecSeqIdle,
        StVecSeqIssue,
        StVecSeqWait,
        StVecSeqDone
    } StateVecAddSeq;
endpackage

// File: rtl/snow64_vector_lane_mux.sv
// snow64_vector_lane_mux: reads lane idx of both operand vectors and rewrites lane idx of the result vector
module snow64_vector_lane_mux #(
    parameter int NUM_LANES = 16
) (
    input  logic [NUM_LANES*16-1:0]      a,
    input  logic [NUM_LANES*16-1:0]      b,
    input  logic [NUM_LANES*16-1:0]      res,
    input  logic [$clog2(NUM_LANES)-1:0] idx,
    input  logic [15:0]                  wdata,
    output logic [15:0]                  a_lane,
    output logic [15:0]                  b_lane,
    output logic [NUM_LANES*16-1:0]      res_next
);
    always_comb begin
        a_lane = a[{idx, 4'b0} +: 16];
        b_lane = b[{idx, 4'b0} +: 16];
        res_next = res;
        res_next[{idx, 4'b0} +: 16] = wdata;
    end
endmodule

// File: rtl/snow64_bfloat16_vector_add_seq.sv
// snow64_bfloat16_vector_add_seq: feeds vector lanes one at a time to the scalar BFloat16 adder;
// defining SNOW64_BFLOAT16_VECTOR_SUB_EN adds A-B support via in_op_sub.
module snow64_bfloat16_vector_add_seq
    import snow64_bfloat16_vector_add_seq_pkg::*;
#(
    parameter int NUM_LANES = NUM_BFLOAT16_LANES
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_start,
    input  logic [NUM_LANES*16-1:0] in_a,
    input  logic [NUM_LANES*16-1:0] in_b,
    input  logic [NUM_LANES-1:0]    in_lane_mask,
    input  logic                    in_op_sub,
    output logic                    out_busy,
    output logic                    out_data_valid,
    output logic [NUM_LANES*16-1:0] out_data,
    output logic                    out_add_start,
    output logic [15:0]             out_add_a,
    output logic [15:0]             out_add_b,
    input  logic                    in_add_data_valid,
    input  logic                    in_add_can_accept_cmd,
    input  logic [15:0]             in_add_data
);
    localparam int VW = NUM_LANES * 16;
    localparam int IW = $clog2(NUM_LANES);
    StateVecAddSeq state, next_state;
    logic [IW-1:0] lane;
    logic [VW-1:0] cap_a, cap_b, res_next;
    logic [NUM_LANES-1:0] cap_mask;
    logic [15:0] a_lane, b_lane, wdata;
    logic lane_en, last, advance;
    snow64_vector_lane_mux #(.NUM_LANES(NUM_LANES)) u_lane_mux (
        .a(cap_a),
        .b(cap_b),
        .res(out_data),
        .idx(lane),
        .wdata(wdata),
        .a_lane(a_lane),
        .b_lane(b_lane),
        .res_next(res_next)
    );
`ifdef SNOW64_BFLOAT16_VECTOR_SUB_EN
    logic cap_sub;
    assign out_add_b = {b_lane[15] ^ cap_sub, b_lane[14:0]};
`else
    logic unused_op_sub;
    assign unused_op_sub = in_op_sub;
    assign out_add_b = b_lane;
`endif
    assign out_add_a = a_lane;
    assign out_busy = state != StVecSeqIdle;
    assign out_data_valid = state == StVecSeqDone;
    always_comb begin
        lane_en = cap_mask[lane];
        last = lane == IW'(NUM_LANES - 1);
        wdata = lane_en ? in_add_data : a_lane;
        out_add_start = state == StVecSeqIssue && lane_en && in_add_can_accept_cmd;
        advance = (state == StVecSeqIssue && !lane_en) || (state == StVecSeqWait && in_add_data_valid);
        next_state = advance ? (last ? StVecSeqDone : StVecSeqIssue)
            : out_add_start ? StVecSeqWait
            : (state == StVecSeqIdle && in_start) ? StVecSeqIssue
            : state == StVecSeqDone ? StVecSeqIdle
            : state;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= StVecSeqIdle;
            lane <= '0;
            cap_a <= '0;
            cap_b <= '0;
            cap_mask <= '0;
            out_data <= '0;
`ifdef SNOW64_BFLOAT16_VECTOR_SUB_EN
            cap_sub <= 1'b0;
`endif
        end else begin
            state <= next_state;
            if (state == StVecSeqIdle && in_start) begin
                cap_a <= in_a;
                cap_b <= in_b;
                cap_mask <= in_lane_mask;
                lane <= '0;
`ifdef SNOW64_BFLOAT16_VECTOR_SUB_EN
                cap_sub <= in_op_sub;
`endif
            end
            if (advance) begin
                out_data <= res_next;
                if (!last) lane <= lane + IW'(1);
            end
        end
    end
endmodule
